// File: rtl/hex_disp_sched_pkg.sv
// Shared types and constants for the hex display scheduler.
package hex_disp_sched_pkg;
  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  localparam int NDIGIT   = 6;
  localparam int NIBBLE_W = 4;
  localparam int VAL_W    = NDIGIT * NIBBLE_W;
  localparam int NREQ_C   = 3;
  localparam int ID_W     = 2;
endpackage

// File: rtl/hex_rr_pick.sv
// Round-robin picker: first requesting index after last_id, modulo 3.
// When only last_id is requesting the search wraps back onto it.
module hex_rr_pick
  import hex_disp_sched_pkg::*;
(
  input  logic [NREQ_C-1:0] req,
  input  logic [ID_W-1:0]   last_id,
  output logic              valid,
  output logic [ID_W-1:0]   idx
);

  logic [ID_W-1:0] cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = NREQ_C; k >= 1; k--) begin
      cand = ID_W'((int'(last_id) + k) % NREQ_C);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/hex_disp_sched.sv
// Round-robin scheduler sharing six hex digits between three requesters.
// Optional macro HEX_DISP_SCHED_PREEMPT_EN gives requester 0 preemptive priority.
module hex_disp_sched
  import hex_disp_sched_pkg::*;
#(
  parameter int HOLD_TICKS = 4,
  parameter int NREQ       = NREQ_C
) (
  input  logic                     CLK_50A,
  input  logic                     reset,
  input  logic                     tick,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*VAL_W-1:0]    req_val,
  input  logic [NREQ*NDIGIT-1:0]   req_blank,
  output logic [NREQ-1:0]          grant,
  output logic [VAL_W-1:0]         disp_val,
  output logic [NDIGIT-1:0]        disp_blank,
  output logic                     busy
);

  localparam logic [3:0] HOLD_LD = 4'(HOLD_TICKS);

  state_t              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     last_id_q, last_id_d;
  logic [3:0]          hold_cnt_q, hold_cnt_d;
  logic [VAL_W-1:0]    disp_val_q, disp_val_d;
  logic [NDIGIT-1:0]   disp_blank_q, disp_blank_d;

  logic [VAL_W-1:0]    val_arr   [NREQ];
  logic [NDIGIT-1:0]   blank_arr [NREQ];
  logic [VAL_W-1:0]    cur_val;
  logic [NDIGIT-1:0]   cur_blank;
  logic                cur_req;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_idx;
  logic [NREQ-1:0]     pick_onehot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign val_arr[gi]   = req_val[gi*VAL_W +: VAL_W];
    assign blank_arr[gi] = req_blank[gi*NDIGIT +: NDIGIT];
  end

  hex_rr_pick u_pick (
    .req     (req),
    .last_id (last_id_q),
    .valid   (pick_valid),
    .idx     (pick_idx)
  );

`ifdef HEX_DISP_SCHED_PREEMPT_EN
  logic req0_q, req0_d;
  assign req0_d = req[0];
  always_ff @(posedge CLK_50A) begin
    if (reset) req0_q <= 1'b0;
    else       req0_q <= req0_d;
  end
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_id_d    = last_id_q;
    hold_cnt_d   = hold_cnt_q;
    disp_val_d   = disp_val_q;
    disp_blank_d = disp_blank_q;
    cur_val      = '0;
    cur_blank    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        cur_val   = val_arr[i];
        cur_blank = blank_arr[i];
      end
    end
    cur_req     = |(req & grant_q);
    pick_onehot = NREQ'(1) << pick_idx;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d    = SHOW;
          grant_d    = pick_onehot;
          last_id_d  = pick_idx;
          hold_cnt_d = HOLD_LD;
        end
      end
      SHOW: begin
        disp_val_d   = cur_val;
        disp_blank_d = cur_blank;
        // Release wins over any expiry, preemption or tick in the same cycle.
        if (!cur_req) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef HEX_DISP_SCHED_PREEMPT_EN
        else if (req[0] && !req0_q && !grant_q[0]) begin
          grant_d    = NREQ'(1);
          last_id_d  = '0;
          hold_cnt_d = HOLD_LD;
        end
        else if (hold_cnt_q == 4'd0 && grant_q[0]) begin
          hold_cnt_d = HOLD_LD;
        end
`endif
        else if (hold_cnt_q == 4'd0) begin
          // Picker wraps onto the current grantee when nobody else asks.
          grant_d    = pick_onehot;
          last_id_d  = pick_idx;
          hold_cnt_d = HOLD_LD;
        end
        else if (tick) begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_50A) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_id_q    <= ID_W'(NREQ_C - 1);
      hold_cnt_q   <= '0;
      disp_val_q   <= '0;
      disp_blank_q <= '1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_id_q    <= last_id_d;
      hold_cnt_q   <= hold_cnt_d;
      disp_val_q   <= disp_val_d;
      disp_blank_q <= disp_blank_d;
    end
  end

  assign grant      = grant_q;
  assign disp_val   = disp_val_q;
  assign disp_blank = disp_blank_q;
  assign busy       = (state_q == SHOW);

endmodule

// File: tb/tb_hex_disp_sched.sv
// Self-checking bench for hex_disp_sched: vector table plus hand-written sequences.
module tb_hex_disp_sched;

  localparam logic [23:0] S0 = 24'h0A0B0C;
  localparam logic [23:0] S1 = 24'h123456;
  localparam logic [23:0] S2 = 24'hABCDEF;
  localparam logic [5:0]  B0 = 6'h01;
  localparam logic [5:0]  B1 = 6'h00;
  localparam logic [5:0]  B2 = 6'h2A;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [2:0]  req;
  logic [71:0] req_val;
  logic [17:0] req_blank;
  logic [2:0]  grant;
  logic [23:0] disp_val;
  logic [5:0]  disp_blank;
  logic        busy;

  hex_disp_sched dut (
    .CLK_50A    (clk),
    .reset      (reset),
    .tick       (tick),
    .req        (req),
    .req_val    (req_val),
    .req_blank  (req_blank),
    .grant      (grant),
    .disp_val   (disp_val),
    .disp_blank (disp_blank),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  grant;
    logic        chk_disp;
    logic [23:0] val;
    logic [5:0]  blank;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        tk;
    logic [2:0]  rq;
    logic [2:0]  grant;
    logic [23:0] val;
    logic [5:0]  blank;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[14];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [2:0] g, input logic c,
                              input logic [23:0] v, input logic [5:0] b);
    exp_t e;
    e.grant = g; e.chk_disp = c; e.val = v; e.blank = b;
    return e;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input string name, input logic rst, input logic tk,
                      input logic [2:0] rq, input exp_t e);
    exp_t got;
    reset = rst; tick = tk; req = rq;
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    check({name, "_grant"}, 32'(grant), 32'(got.grant));
    check({name, "_busy"}, 32'(busy), 32'(|got.grant));
    if (got.chk_disp) begin
      check({name, "_val"}, 32'(disp_val), 32'(got.val));
      check({name, "_blank"}, 32'(disp_blank), 32'(got.blank));
    end
    $display("%0t %s rst=%b tick=%b req=%b grant=%b busy=%b val=%h blank=%h",
             $time, name, rst, tk, rq, grant, busy, disp_val, disp_blank);
  endtask

  function automatic logic [23:0] slice_val(input logic [2:0] g);
    return g[0] ? S0 : g[1] ? S1 : g[2] ? S2 : 24'h0;
  endfunction
  function automatic logic [5:0] slice_blank(input logic [2:0] g);
    return g[0] ? B0 : g[1] ? B1 : g[2] ? B2 : 6'h3F;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rot [3];
    logic [2:0] eg, prev_g;
    reset = 1'b1; tick = 1'b0; req = 3'b000;
    req_val   = {S2, S1, S0};
    req_blank = {B2, B1, B0};
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;

    //          rst   tick  req     grant   disp_val      blank
    tbl[0]  = '{1'b1, 1'b0, 3'b000, 3'b000, 24'h000000, 6'h3F};
    tbl[1]  = '{1'b0, 1'b0, 3'b010, 3'b010, 24'h000000, 6'h3F};
    tbl[2]  = '{1'b0, 1'b0, 3'b010, 3'b010, S1,         B1};
    tbl[3]  = '{1'b0, 1'b1, 3'b010, 3'b010, S1,         B1};
    tbl[4]  = '{1'b0, 1'b0, 3'b000, 3'b000, S1,         B1};
    tbl[5]  = '{1'b0, 1'b1, 3'b000, 3'b000, S1,         B1};
    tbl[6]  = '{1'b0, 1'b0, 3'b100, 3'b100, S1,         B1};
    tbl[7]  = '{1'b0, 1'b0, 3'b100, 3'b100, S2,         B2};
    tbl[8]  = '{1'b0, 1'b0, 3'b000, 3'b000, S2,         B2};
    tbl[9]  = '{1'b0, 1'b0, 3'b000, 3'b000, S2,         B2};
    tbl[10] = '{1'b0, 1'b0, 3'b001, 3'b001, S2,         B2};
    tbl[11] = '{1'b0, 1'b0, 3'b001, 3'b001, S0,         B0};
    tbl[12] = '{1'b1, 1'b0, 3'b001, 3'b000, 24'h000000, 6'h3F};
    tbl[13] = '{1'b0, 1'b0, 3'b000, 3'b000, 24'h000000, 6'h3F};

    for (int i = 0; i < 14; i++)
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].tk, tbl[i].rq,
           mk(tbl[i].grant, 1'b1, tbl[i].val, tbl[i].blank));

    // Rotation with all three requesting and a tick every 10 cycles.
    step("rot_rst", 1'b1, 1'b0, 3'b000, mk(3'b000, 1'b1, 24'h0, 6'h3F));
    prev_g = 3'b000;
    for (int k = 0; k < 126; k++) begin
`ifdef HEX_DISP_SCHED_PREEMPT_EN
      eg = 3'b001;
`else
      eg = rot[(k / 40) % 3];
`endif
      step($sformatf("rot%0d", k), 1'b0, (k % 10) == 9, 3'b111,
           mk(eg, 1'b1, (k == 0) ? 24'h0 : slice_val(prev_g),
              (k == 0) ? 6'h3F : slice_blank(prev_g)));
      prev_g = eg;
    end

    // Hold expiry coinciding with the grantee releasing while req[2] waits.
    step("exp_rst", 1'b1, 1'b0, 3'b000, mk(3'b000, 1'b0, 24'h0, 6'h0));
    step("exp_g1",  1'b0, 1'b0, 3'b010, mk(3'b010, 1'b0, 24'h0, 6'h0));
    for (int t = 0; t < 4; t++)
      step($sformatf("exp_t%0d", t), 1'b0, 1'b1, 3'b010, mk(3'b010, 1'b1, S1, B1));
    step("exp_rel",  1'b0, 1'b1, 3'b100, mk(3'b000, 1'b1, S1, B1));
    step("exp_g2",   1'b0, 1'b0, 3'b100, mk(3'b100, 1'b1, S1, B1));
    step("exp_show", 1'b0, 1'b0, 3'b100, mk(3'b100, 1'b1, S2, B2));

    // Reset in the middle of SHOW aborts the grant at once.
    step("rs_abort", 1'b1, 1'b1, 3'b100, mk(3'b000, 1'b1, 24'h0, 6'h3F));

    // Requester 0 rising while requester 2 holds the display.
    step("pre_g2", 1'b0, 1'b0, 3'b100, mk(3'b100, 1'b0, 24'h0, 6'h0));
`ifdef HEX_DISP_SCHED_PREEMPT_EN
    step("pre_r0", 1'b0, 1'b0, 3'b101, mk(3'b001, 1'b1, S2, B2));
    step("pre_h0", 1'b0, 1'b0, 3'b101, mk(3'b001, 1'b1, S0, B0));
    for (int t = 0; t < 4; t++)
      step($sformatf("pre_t%0d", t), 1'b0, 1'b1, 3'b101, mk(3'b001, 1'b0, 24'h0, 6'h0));
    step("pre_exp", 1'b0, 1'b0, 3'b101, mk(3'b001, 1'b0, 24'h0, 6'h0));
`else
    step("pre_r0", 1'b0, 1'b0, 3'b101, mk(3'b100, 1'b1, S2, B2));
    step("pre_h0", 1'b0, 1'b0, 3'b101, mk(3'b100, 1'b1, S2, B2));
    for (int t = 0; t < 4; t++)
      step($sformatf("pre_t%0d", t), 1'b0, 1'b1, 3'b101, mk(3'b100, 1'b0, 24'h0, 6'h0));
    step("pre_exp", 1'b0, 1'b0, 3'b101, mk(3'b001, 1'b1, S2, B2));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
